// File: rtl/hbridge_driver_pkg.sv
// Shared constants for the H-bridge driver: FSM state encoding and direction values.
package hbridge_driver_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SYNC = 2'd1,
      RUN  = 2'd2,
      DEAD = 2'd3
   } state_e;

   localparam logic DIR_FWD = 1'b0;
   localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/hbridge_driver_sync2.sv
// Two-flop synchronizer for the asynchronous direction switch, synchronous active-high reset.
module hbridge_driver_sync2 (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/hbridge_driver.sv
// H-bridge driver: gates the PWM waveform onto IN1/IN2 by direction, with dead time on
// reversal and re-arming only at a PWM period start so the first pulse is full length.
module hbridge_driver
   import hbridge_driver_pkg::*;
#(
   parameter int DEAD_CYCLES = 16,
   parameter int CNT_W       = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       PWM_IN,
   input  logic       E,
   input  logic       DIR,
   input  logic       EN,
   output logic       IN1,
   output logic       IN2,
   output logic       DIR_ACT,
   output logic       BUSY,
   output logic [1:0] DBG_STATE
);

   localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);

   state_e           state_q, state_d;
   logic             dir_act_q, dir_act_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             e_q;
   logic             in1_q, in1_d;
   logic             in2_q, in2_d;
   logic             busy_q, busy_d;
   logic             run_d;
   logic             dir_s;
   logic             start;

   hbridge_driver_sync2 u_sync2 (
      .clk_i (CLK),
      .rst_i (RST),
      .d_i   (DIR),
      .q_o   (dir_s)
   );

   // Only the rising edge of E counts, so a multi-cycle E cannot re-trigger.
   assign start = E & ~e_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         dir_act_q <= DIR_FWD;
         cnt_q     <= '0;
         e_q       <= 1'b0;
         in1_q     <= 1'b0;
         in2_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         dir_act_q <= dir_act_d;
         cnt_q     <= cnt_d;
         e_q       <= E;
         in1_q     <= in1_d;
         in2_q     <= in2_d;
         busy_q    <= busy_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      dir_act_d = dir_act_q;
      cnt_d     = cnt_q;
      case (state_q)
         IDLE: begin
            if (EN) begin
               state_d   = SYNC;
               dir_act_d = dir_s;
            end
         end
         SYNC: begin
            if (!EN)        state_d = IDLE;
            else if (start) state_d = RUN;
         end
         RUN: begin
            if (!EN) begin
               state_d = IDLE;
            end else if (dir_s != dir_act_q) begin
               state_d = DEAD;
               cnt_d   = DEAD_LOAD;
            end
         end
         DEAD: begin
            // Direction is re-sampled on exit; a bounced switch still pays the full dead time.
            if (!EN) begin
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               state_d   = SYNC;
               dir_act_d = dir_s;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      run_d  = (state_d == RUN);
      in1_d  = run_d & (dir_act_d == DIR_FWD) & PWM_IN;
      in2_d  = run_d & (dir_act_d == DIR_REV) & PWM_IN;
      busy_d = (state_d == DEAD) | (state_d == SYNC);
   end

   assign IN1       = in1_q;
   assign IN2       = in2_q;
   assign DIR_ACT   = dir_act_q;
   assign BUSY      = busy_q;
   assign DBG_STATE = state_q;

endmodule

// File: doc/hbridge_driver.md
Name: hbridge_driver

Overview:
- Downstream consumer of the PWM block: takes its PWM_OUT and period-start strobe E and drives the two H-bridge inputs (IN1/IN2) of the motor driver.
- Adds direction control from a switch, an enable, and break-before-make dead time on direction reversal.
- Re-arms drive only at a PWM period boundary, so the first pulse after a change is always a full-length duty pulse.

Parameters:
- DEAD_CYCLES, 16, CLK cycles with both bridge inputs low on a direction change; legal range 1..255.
- CNT_W, 8, width of the dead-time counter; must hold DEAD_CYCLES-1.

Ports:
- CLK  input  1  system clock, all logic on posedge CLK.
- RST  input  1  synchronous, active-high reset.
- PWM_IN  input  1  PWM waveform from the PWM block (PWM_OUT).
- E  input  1  period-start strobe from the PWM block, high while TCR==0.
- DIR  input  1  requested direction from a switch, asynchronous: 0=forward, 1=reverse.
- EN  input  1  drive enable, synchronous to CLK.
- IN1  output  1  bridge input A; forward drive.
- IN2  output  1  bridge input B; reverse drive.
- DIR_ACT  output  1  direction currently applied to the bridge.
- BUSY  output  1  high in DEAD or SYNC (direction change or re-arm in progress).

Behaviour:
- Reset values when RST=1 at posedge: state=IDLE, IN1=0, IN2=0, DIR_ACT=0, BUSY=0, counter=0, synchronizer and E-history flops=0. RST takes priority over every other input.
- DIR path: 2-flop synchronizer produces dir_s, 2-cycle latency.
- E path: e_q is a 1-flop history of E; start = E & ~e_q (rising edge only).
- States: IDLE, SYNC, RUN, DEAD.
- IDLE:
  - EN=1 -> SYNC; DIR_ACT<=dir_s.
- SYNC:
  - EN=0 -> IDLE.
  - Otherwise start=1 -> RUN.
- RUN:
  - EN=0 -> IDLE.
  - Otherwise dir_s!=DIR_ACT -> DEAD; counter<=DEAD_CYCLES-1.
- DEAD:
  - EN=0 -> IDLE.
  - Otherwise counter==0 -> SYNC with DIR_ACT<=dir_s.
  - Otherwise counter decrements.
- Outputs are registered, 1-cycle latency from PWM_IN:
  - IN1 <= (next state==RUN) & ~DIR_ACT_next & PWM_IN.
  - IN2 <= (next state==RUN) & DIR_ACT_next & PWM_IN.
- Invariant: IN1 & IN2 is never 1 in any cycle.
- Dead time: both outputs are 0 for at least DEAD_CYCLES consecutive cycles between the last IN1 high and the first IN2 high, and vice versa.
- DIR bouncing back during DEAD: the dead time still completes. DIR_ACT takes dir_s as sampled on exit; if it equals the old direction, resume in SYNC anyway.
- DIR change in SYNC: no effect until RUN. RUN re-checks and enters DEAD on the next cycle if a mismatch remains.
- EN drop has priority over everything: bridge coasts (0,0) on the next cycle, from any state.
- start coincident with the EN rising edge: the IDLE->SYNC cycle consumes it, so RUN waits for the following period start.
- RST mid-DEAD or mid-RUN: outputs are 0 on the next cycle. The counter is cleared and is not resumed.
- PWM_IN held constant 1 (100% duty) or 0 (0% duty) is passed through unchanged in RUN.
- BUSY = (state==DEAD)|(state==SYNC), registered alongside the outputs.

Decomposition:
- Shared package: the state encoding constants (IDLE=2'd0, SYNC=2'd1, RUN=2'd2, DEAD=2'd3) and the direction constants DIR_FWD=0, DIR_REV=1.
- One natural sub-module, sync2: a 2-flop synchronizer with synchronous active-high reset, used for DIR.
- FSM, counter and output registers stay in hbridge_driver.

Test Plan:
- Reset and enable: RST high 3 cycles, then EN=1, DIR=0, PWM_IN toggling. Required: IN1=IN2=0 until the first E rising edge after EN. Then IN1 follows PWM_IN with 1-cycle delay, IN2=0, DIR_ACT=0, BUSY high only in SYNC.
- Reversal: in RUN forward, DIR 0->1. Required:
  - IN1 goes 0 within 4 cycles (2 sync + 1 FSM + 1 output).
  - Both outputs are 0 for ≥16 cycles (DEAD_CYCLES=16).
  - IN2 starts only at the next E rising edge; DIR_ACT=1.
- Glitch during dead time: DIR 0->1, then back to 0 after 5 cycles. Required: full 16-cycle dead time, then DIR_ACT=0, IN1 resumes at the next period start, IN2 never high.
- Enable drop: EN 1->0 in RUN and again mid-DEAD. Required: IN1=IN2=0 on the next cycle, state IDLE, BUSY=0. Re-enable waits for the next E edge.
- Reset mid-operation: assert RST in RUN with PWM_IN=1. Required: IN1=0 on the next cycle, DIR_ACT=0, no output until EN plus E sequence recurs.
- Overlap check: random DIR/EN/PWM_IN for 10k cycles with DEAD_CYCLES=1 and 255. Required:
  - Assertion IN1&IN2==0 never fires.
  - The measured zero-gap on every direction flip is ≥ DEAD_CYCLES.
